// File: rtl/sm_uart_tx.sv
// Bus-slave 8N1 UART transmitter: DATA/STATUS/DIV registers, byte FIFO and a
// serialiser whose bit period is DIV+1 clocks, re-sampled at every bit boundary.
module sm_uart_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16,
    parameter int DIV_RESET  = 433
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bSel,
    input  logic [31:0] bAddr,
    input  logic        bWrite,
    input  logic [31:0] bWData,
    output logic [31:0] bRData,
    output logic        txd
);

    // state  | meaning
    // IDLE   | line high, waiting for a queued byte
    // START  | start bit (low)
    // DATA   | eight data bits, LSB first
    // STOP   | stop bit (high)
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]           mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 ovf;
    logic [DIV_WIDTH-1:0] div_reg;
    logic [DIV_WIDTH-1:0] baud_cnt;
    state_t               state;
    logic [7:0]           shreg;
    logic [2:0]           bit_cnt;

    logic       wr_en, full, empty, busy, push, pop;
    logic [1:0] reg_idx;
    logic       unused_ok;

    assign reg_idx   = bAddr[3:2];
    assign wr_en     = bSel & bWrite;
    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign busy      = (state != ST_IDLE);
    assign push      = wr_en && (reg_idx == 2'd0) && !full;
    assign pop       = (state == ST_IDLE) && !empty;
    assign unused_ok = ^{bAddr, bWData};

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bWData[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            div_reg <= DIV_WIDTH'(DIV_RESET);
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // a drop on a full FIFO outranks a clear in the same cycle
            if (wr_en && (reg_idx == 2'd0) && full)
                ovf <= 1'b1;
            else if (wr_en && (reg_idx == 2'd1) && bWData[3])
                ovf <= 1'b0;
            if (wr_en && (reg_idx == 2'd2))
                div_reg <= bWData[DIV_WIDTH-1:0];
        end
    end

    // baud_cnt is reloaded from div_reg only at bit starts, so a DIV write
    // never stretches or shortens the bit in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            txd      <= 1'b1;
            shreg    <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    txd     <= 1'b1;
                    bit_cnt <= '0;
                    if (!empty) begin
                        shreg    <= mem[rd_ptr];
                        txd      <= 1'b0;
                        baud_cnt <= div_reg;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_cnt == '0) begin
                        txd      <= shreg[0];
                        shreg    <= {1'b0, shreg[7:1]};
                        baud_cnt <= div_reg;
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - DIV_WIDTH'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= div_reg;
                        if (bit_cnt == 3'd7) begin
                            txd   <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            txd     <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt - DIV_WIDTH'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_cnt == '0)
                        state <= ST_IDLE;
                    else
                        baud_cnt <= baud_cnt - DIV_WIDTH'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bRData = '0;
        case (reg_idx)
            2'd1:    bRData = {16'b0, 8'(count), 4'b0, ovf, empty, full, busy};
            2'd2:    bRData = 32'(div_reg);
            default: bRData = '0;
        endcase
    end

endmodule

// File: tb/tb_sm_uart_tx.sv
// Self-checking bench for sm_uart_tx: expected line waveforms come from frame
// arithmetic (bit index = clock offset / bit period), not from the FSM.
module tb_sm_uart_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bSel, bWrite;
    logic [31:0] bAddr, bWData, bRData;
    logic        txd;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    localparam logic [31:0] A_DATA = 32'h7f30;
    localparam logic [31:0] A_STAT = 32'h7f34;
    localparam logic [31:0] A_DIV  = 32'h7f38;
    localparam logic [31:0] A_RSV  = 32'h7f3c;

    sm_uart_tx dut (
        .clk(clk), .rst_n(rst_n), .bSel(bSel), .bAddr(bAddr), .bWrite(bWrite),
        .bWData(bWData), .bRData(bRData), .txd(txd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // expected line level at clock offset idx into a frame with fixed period
    function automatic logic exp_txd(input logic [7:0] b, input int div, input int idx);
        int seg;
        seg = idx / (div + 1);
        if (seg == 0) return 1'b0;
        if (seg <= 8) return b[seg-1];
        return 1'b1;
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bSel = 1'b1; bWrite = 1'b1; bAddr = a; bWData = d;
        @(negedge clk);
        bSel = 1'b0; bWrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bAddr = a;
        #1 d = bRData;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        rst_n = 1'b0; bSel = 1'b0; bWrite = 1'b0; bAddr = '0; bWData = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", txd); end
        rd(A_STAT, d); checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL reset_status: got %h expected 00000004", d); end
        rd(A_DIV, d); checks++;
        if (d !== 32'd433) begin errors++; $display("FAIL reset_div: got %0d expected 433", d); end
        wr(A_RSV, 32'hdeadbeef);
        rd(A_RSV, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reserved_read: got %h expected 0", d); end
        rd(A_DATA, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL data_read: got %h expected 0", d); end
    endtask

    task automatic test_single;
        logic [31:0] d;
        int busy_cnt;
        logic eb, et;
        wr(A_DIV, 32'd3);
        rd(A_DIV, d); checks++;
        if (d !== 32'd3) begin errors++; $display("FAIL div_readback: got %0d expected 3", d); end
        wr(A_DATA, 32'h55);
        checks++;
        if (txd !== 1'b1) begin errors++; $display("FAIL single_latency: got %b expected 1", txd); end
        rd(A_STAT, d); checks++;
        if (d !== 32'h100) begin errors++; $display("FAIL single_status: got %h expected 00000100", d); end
        busy_cnt = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            et = (i < 40) ? exp_txd(8'h55, 3, i) : 1'b1;
            eb = (i < 40);
            busy_cnt += bRData[0];
            checks++;
            if (txd !== et) begin errors++; $display("FAIL single_txd[%0d]: got %b expected %b", i, txd, et); end
            checks++;
            if (bRData[0] !== eb) begin errors++; $display("FAIL single_busy[%0d]: got %b expected %b", i, bRData[0], eb); end
        end
        checks++;
        if (busy_cnt != 40) begin errors++; $display("FAIL busy_len: got %0d expected 40", busy_cnt); end
    endtask

    task automatic test_random;
        logic [7:0] bytes [4];
        int div, n, len, total, f, off;
        logic et;
        repeat (4) begin
            div = $urandom_range(0, 4);
            n = $urandom_range(1, 4);
            for (int i = 0; i < 4; i++) bytes[i] = 8'($urandom);
            wr(A_DIV, 32'(div));
            len = 10 * (div + 1) + 1;
            total = n * len + 3;
            for (int t = 0; t <= total; t++) begin
                if (t < n) begin
                    bSel = 1'b1; bWrite = 1'b1; bAddr = A_DATA; bWData = 32'(bytes[t]);
                end else begin
                    bSel = 1'b0; bWrite = 1'b0;
                end
                @(negedge clk);
                if (t >= 1) begin
                    f = (t - 1) / len;
                    off = (t - 1) % len;
                    et = (f < n && off < len - 1) ? exp_txd(bytes[f], div, off) : 1'b1;
                    checks++;
                    if (txd !== et) begin
                        errors++;
                        $display("FAIL random_txd div=%0d t=%0d: got %b expected %b", div, t, txd, et);
                    end
                end
            end
        end
    endtask

    task automatic test_overflow;
        logic [31:0] d;
        logic [7:0] rx;
        int k, s0, tgt, lows;
        logic start_b, stop_b;
        wr(A_DIV, 32'd1000);
        for (int i = 0; i < 6; i++) begin
            wr(A_DATA, 32'(i + 1));
            if (i == 0) k = cyc;
        end
        s0 = k + 1;
        rd(A_STAT, d); checks++;
        if (d !== 32'h40B) begin errors++; $display("FAIL ovf_status: got %h expected 0000040b", d); end
        wr(A_STAT, 32'h0);
        rd(A_STAT, d); checks++;
        if (d !== 32'h40B) begin errors++; $display("FAIL ovf_keep: got %h expected 0000040b", d); end
        wr(A_STAT, 32'h8);
        rd(A_STAT, d); checks++;
        if (d !== 32'h403) begin errors++; $display("FAIL ovf_clear: got %h expected 00000403", d); end
        wr(A_STAT, 32'h0);
        rd(A_STAT, d); checks++;
        if (d !== 32'h403) begin errors++; $display("FAIL ovf_stay_clear: got %h expected 00000403", d); end
        for (int f = 0; f < 5; f++) begin
            start_b = 1'b1; stop_b = 1'b0; rx = '0;
            for (int j = 0; j < 10; j++) begin
                tgt = s0 + f * 10011 + j * 1001 + 500;
                while (cyc < tgt) @(negedge clk);
                if (j == 0) start_b = txd;
                else if (j == 9) stop_b = txd;
                else rx[j-1] = txd;
            end
            checks++;
            if (start_b !== 1'b0 || stop_b !== 1'b1 || rx !== 8'(f + 1)) begin
                errors++;
                $display("FAIL ovf_frame%0d: got %h start=%b stop=%b expected %h", f, rx, start_b, stop_b, f + 1);
            end
        end
        while (cyc < s0 + 5 * 10011) @(negedge clk);
        rd(A_STAT, d); checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL ovf_drained: got %h expected 00000004", d); end
        lows = 0;
        repeat (2000) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0) begin errors++; $display("FAIL ovf_extra_frame: got %0d low clocks expected 0", lows); end
    endtask

    task automatic test_div_change;
        logic [31:0] d;
        int seg;
        logic et;
        wr(A_DIV, 32'd3);
        wr(A_DATA, 32'hA3);
        for (int t = 1; t <= 67; t++) begin
            if (t == 14) begin
                bSel = 1'b1; bWrite = 1'b1; bAddr = A_DIV; bWData = 32'd7;
            end else begin
                bSel = 1'b0; bWrite = 1'b0;
            end
            @(negedge clk);
            // start, bit0..bit2 at 4 clocks; bit3..bit7 and stop at 8 clocks
            seg = (t - 1 < 16) ? (t - 1) / 4 : 4 + (t - 17) / 8;
            if (seg == 0) et = 1'b0;
            else if (seg <= 8) et = (8'hA3 >> (seg - 1)) & 1'b1;
            else et = 1'b1;
            checks++;
            if (txd !== et) begin errors++; $display("FAIL divchg_txd t=%0d: got %b expected %b", t, txd, et); end
        end
        rd(A_DIV, d); checks++;
        if (d !== 32'd7) begin errors++; $display("FAIL divchg_div: got %0d expected 7", d); end
        rd(A_STAT, d); checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL divchg_status: got %h expected 00000004", d); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        int lows;
        wr(A_DIV, 32'd3);
        wr(A_DATA, 32'h00);
        wr(A_DATA, 32'hFF);
        wr(A_DATA, 32'hFF);
        repeat (8) @(negedge clk);
        checks++;
        if (txd !== 1'b0) begin errors++; $display("FAIL mid_pre_txd: got %b expected 0", txd); end
        rd(A_STAT, d); checks++;
        if (d !== 32'h201) begin errors++; $display("FAIL mid_pre_status: got %h expected 00000201", d); end
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (txd !== 1'b1) begin errors++; $display("FAIL mid_async_txd: got %b expected 1", txd); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd(A_STAT, d); checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL mid_post_status: got %h expected 00000004", d); end
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0) begin errors++; $display("FAIL mid_no_frames: got %0d low clocks expected 0", lows); end
        rd(A_STAT, d); checks++;
        if (d !== 32'h4) begin errors++; $display("FAIL mid_final_status: got %h expected 00000004", d); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_random;
        test_overflow;
        test_div_change;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
